// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, instruction field positions,
// FSM state encoding and the 4-bit immediate sign-extension helper.
package id_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of fetch-side, MEM/WB-side and ID/EX latch signals around the decode stage.
// Handshake: fetch presents id_instr every cycle; while STALL is high fetch must hold the
// same instruction; ex_valid marks a real instruction (not a bubble) in the ID/EX latch.
interface id_stage_if;
    logic [15:0] id_instr;
    logic [15:0] id_instr_addr;
    logic        mem_wr_en;
    logic [3:0]  mem_rd;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;

    logic        STALL;
    logic        BRANCH;
    logic [15:0] branch_instr_addr;

    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [3:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_imm;
    logic [15:0] ex_instr_addr;
    logic [1:0]  dbg_state;

    modport master (
        output id_instr, id_instr_addr, mem_wr_en, mem_rd, wb_we, wb_rd, wb_data,
        input  STALL, BRANCH, branch_instr_addr,
        input  ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm, ex_instr_addr, dbg_state
    );

    modport slave (
        input  id_instr, id_instr_addr, mem_wr_en, mem_rd, wb_we, wb_rd, wb_data,
        output STALL, BRANCH, branch_instr_addr,
        output ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm, ex_instr_addr, dbg_state
    );
endinterface

// File: rtl/id_regfile.sv
// 16x16 register file: two async read ports, one sync write port, r0 hardwired to zero.
// With ID_WB_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module id_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ra_addr,
    output logic [15:0] ra_data,
    input  logic [3:0]  rb_addr,
    output logic [15:0] rb_data,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata
);
    logic [15:0] regs [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we && waddr != 4'd0) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign ra_data = (ra_addr == 4'd0) ? 16'd0 :
                     (we && waddr == ra_addr) ? wdata : regs[ra_addr];
    assign rb_data = (rb_addr == 4'd0) ? 16'd0 :
                     (we && waddr == rb_addr) ? wdata : regs[rb_addr];
`else
    assign ra_data = (ra_addr == 4'd0) ? 16'd0 : regs[ra_addr];
    assign rb_data = (rb_addr == 4'd0) ? 16'd0 : regs[rb_addr];
`endif

endmodule

// File: rtl/id_stage.sv
// Decode stage: register read, hazard stalls, BEQ/JMP resolution with wrong-path flush,
// HALT handling and the ID/EX latch. Optional WB->ID bypass via ID_WB_BYPASS_EN.
module id_stage
    import id_pkg::*;
#(
    parameter int          FLUSH_DEPTH = 2,
    parameter logic [15:0] RESET_ADDR  = 16'd8
) (
    input  logic     CLOCK_50,
    input  logic     reset_n,
    id_stage_if.slave bus
);
    localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] flush_cnt;

    logic [3:0]  op, rd, rs, rt, b_addr;
    logic [15:0] imm, a_data, b_data;
    logic        use_a, use_b, issues;

    assign op  = bus.id_instr[OP_MSB:OP_LSB];
    assign rd  = bus.id_instr[RD_MSB:RD_LSB];
    assign rs  = bus.id_instr[RS_MSB:RS_LSB];
    assign rt  = bus.id_instr[RT_MSB:RT_LSB];
    assign imm = sext4(bus.id_instr[RT_MSB:RT_LSB]);

    // SW stores rd and BEQ compares rd, so port B reads rd for those ops.
    assign b_addr = (op == OP_SW || op == OP_BEQ) ? rd : rt;

    always_comb begin
        use_a  = 1'b0;
        use_b  = 1'b0;
        issues = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin use_a = 1'b1; use_b = 1'b1; issues = 1'b1; end
            OP_ADDI, OP_LW:                begin use_a = 1'b1; issues = 1'b1; end
            OP_SW:                         begin use_a = 1'b1; use_b = 1'b1; issues = 1'b1; end
            OP_BEQ:                        begin use_a = 1'b1; use_b = 1'b1; end
            OP_NOP:                        ;
            default:                       ;
        endcase
    end

    id_regfile u_regfile (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .ra_addr (rs),
        .ra_data (a_data),
        .rb_addr (b_addr),
        .rb_data (b_data),
        .we      (bus.wb_we),
        .waddr   (bus.wb_rd),
        .wdata   (bus.wb_data)
    );

    function automatic logic src_hit(input logic [3:0] r, input logic ua, input logic ub,
                                     input logic [3:0] ra, input logic [3:0] rb);
        return (r != 4'd0) && ((ua && r == ra) || (ub && r == rb));
    endfunction

    logic ex_writes, load_use, beq_haz, wb_haz, run_stall, beq_taken;
    logic [15:0] beq_target, jmp_target;

    assign ex_writes = bus.ex_valid && (bus.ex_opcode != OP_SW);
    assign load_use  = bus.ex_valid && (bus.ex_opcode == OP_LW) &&
                       src_hit(bus.ex_rd, use_a, use_b, rs, b_addr);
    assign beq_haz   = (op == OP_BEQ) &&
                       ((ex_writes && src_hit(bus.ex_rd, use_a, use_b, rs, b_addr)) ||
                        (bus.mem_wr_en && src_hit(bus.mem_rd, use_a, use_b, rs, b_addr)));
`ifdef ID_WB_BYPASS_EN
    assign wb_haz = 1'b0;
`else
    // Without forwarding the register file only has the new value after this edge.
    assign wb_haz = bus.wb_we && src_hit(bus.wb_rd, use_a, use_b, rs, b_addr);
`endif
    assign run_stall = load_use || beq_haz || wb_haz;

    assign bus.STALL     = (state == ST_HALTED) || ((state == ST_RUN) && run_stall);
    assign bus.dbg_state = state;

    assign beq_taken  = (a_data == b_data);
    assign beq_target = bus.id_instr_addr + 16'd1 + imm;
    assign jmp_target = {bus.id_instr_addr[15:12], bus.id_instr[11:0]};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= ST_RUN;
            flush_cnt             <= '0;
            bus.BRANCH            <= 1'b0;
            bus.branch_instr_addr <= '0;
            bus.ex_valid          <= 1'b0;
            bus.ex_opcode         <= '0;
            bus.ex_rd             <= '0;
            bus.ex_a              <= '0;
            bus.ex_b              <= '0;
            bus.ex_imm            <= '0;
            bus.ex_instr_addr     <= RESET_ADDR;
        end else begin
            // Default every cycle is a bubble into EX and no branch pulse.
            bus.BRANCH    <= 1'b0;
            bus.ex_valid  <= 1'b0;
            bus.ex_opcode <= '0;
            bus.ex_rd     <= '0;
            bus.ex_a      <= '0;
            bus.ex_b      <= '0;
            bus.ex_imm    <= '0;
            case (state)
                ST_RUN: begin
                    if (!run_stall) begin
                        if (issues) begin
                            bus.ex_valid      <= 1'b1;
                            bus.ex_opcode     <= op;
                            bus.ex_rd         <= rd;
                            bus.ex_a          <= use_a ? a_data : 16'd0;
                            bus.ex_b          <= use_b ? b_data : 16'd0;
                            bus.ex_imm        <= imm;
                            bus.ex_instr_addr <= bus.id_instr_addr;
                        end else if ((op == OP_BEQ && beq_taken) || op == OP_JMP) begin
                            bus.BRANCH            <= 1'b1;
                            bus.branch_instr_addr <= (op == OP_JMP) ? jmp_target : beq_target;
                            state                 <= ST_FLUSH;
                            flush_cnt             <= CNT_W'(FLUSH_DEPTH - 1);
                        end else if (op == OP_HALT) begin
                            state <= ST_HALTED;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) state <= ST_RUN;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, ALU issue, load-use, BEQ/JMP with flush, HALT, WB hazard.
// Expectations for the WB same-cycle case follow ID_WB_BYPASS_EN.
module tb_id_stage;
    import id_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage #(.FLUSH_DEPTH(2), .RESET_ADDR(16'd8)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] addr);
        bus.id_instr      = instr;
        bus.id_instr_addr = addr;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive(16'h0000, 16'h0000);
        bus.mem_wr_en = 1'b0;
        bus.mem_rd    = 4'd0;
        bus.wb_we     = 1'b0;
        bus.wb_rd     = 4'd0;
        bus.wb_data   = 16'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
        drive(16'h0000, 16'h0000);
        bus.wb_we = 1'b1; bus.wb_rd = r; bus.wb_data = d;
        tick();
        bus.wb_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(16'h1312, 16'h0020);
        tick();
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL t1_pre_valid got=%0h exp=1", bus.ex_valid); end
        drive(16'h9ABC, 16'h0021);
        tick();
        checks++; if (bus.BRANCH !== 1'b1) begin failures++; $display("FAIL t1_pre_branch got=%0h exp=1", bus.BRANCH); end
        checks++; if (bus.branch_instr_addr !== 16'h0ABC) begin failures++; $display("FAIL t1_pre_target got=%h exp=0abc", bus.branch_instr_addr); end
        checks++; if (bus.dbg_state !== ST_FLUSH) begin failures++; $display("FAIL t1_pre_flush got=%0h exp=%0h", bus.dbg_state, ST_FLUSH); end
        drive(16'h1312, 16'h0022);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t1_ex_valid got=%0h exp=0", bus.ex_valid); end
        checks++; if (bus.ex_opcode !== 4'd0 || bus.ex_rd !== 4'd0) begin failures++; $display("FAIL t1_ex_op_rd got=%0h/%0h exp=0/0", bus.ex_opcode, bus.ex_rd); end
        checks++; if (bus.ex_a !== 16'd0 || bus.ex_b !== 16'd0 || bus.ex_imm !== 16'd0) begin failures++; $display("FAIL t1_ex_data got=%h/%h/%h exp=0", bus.ex_a, bus.ex_b, bus.ex_imm); end
        checks++; if (bus.ex_instr_addr !== 16'h0008) begin failures++; $display("FAIL t1_ex_addr got=%h exp=0008", bus.ex_instr_addr); end
        checks++; if (bus.BRANCH !== 1'b0 || bus.branch_instr_addr !== 16'h0) begin failures++; $display("FAIL t1_branch got=%0h/%h exp=0/0000", bus.BRANCH, bus.branch_instr_addr); end
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t1_stall got=%0h exp=0", bus.STALL); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (bus.dbg_state !== ST_RUN) begin failures++; $display("FAIL t1_state got=%0h exp=%0h", bus.dbg_state, ST_RUN); end
    endtask

    task automatic test_alu();
        apply_reset();
        wb_write(4'd1, 16'd5);
        wb_write(4'd2, 16'd7);
        wb_write(4'd0, 16'h1234);
        drive(16'h1312, 16'h0030);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t2_stall got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 4'd1 || bus.ex_rd !== 4'd3) begin failures++; $display("FAIL t2_add_ctl got=%0h/%0h/%0h exp=1/1/3", bus.ex_valid, bus.ex_opcode, bus.ex_rd); end
        checks++; if (bus.ex_a !== 16'd5 || bus.ex_b !== 16'd7) begin failures++; $display("FAIL t2_add_ops got=%h/%h exp=0005/0007", bus.ex_a, bus.ex_b); end
        checks++; if (bus.ex_instr_addr !== 16'h0030) begin failures++; $display("FAIL t2_add_addr got=%h exp=0030", bus.ex_instr_addr); end
        drive(16'h541F, 16'h0031);
        tick();
        checks++; if (bus.ex_opcode !== 4'd5 || bus.ex_rd !== 4'd4 || bus.ex_a !== 16'd5 || bus.ex_imm !== 16'hFFFF) begin failures++; $display("FAIL t2_addi got=%0h/%0h/%h/%h exp=5/4/0005/ffff", bus.ex_opcode, bus.ex_rd, bus.ex_a, bus.ex_imm); end
        drive(16'h7213, 16'h0032);
        tick();
        checks++; if (bus.ex_opcode !== 4'd7 || bus.ex_a !== 16'd5 || bus.ex_b !== 16'd7 || bus.ex_imm !== 16'd3) begin failures++; $display("FAIL t2_sw got=%0h/%h/%h/%h exp=7/0005/0007/0003", bus.ex_opcode, bus.ex_a, bus.ex_b, bus.ex_imm); end
        drive(16'h1100, 16'h0033);
        tick();
        checks++; if (bus.ex_a !== 16'd0 || bus.ex_b !== 16'd0) begin failures++; $display("FAIL t2_r0 got=%h/%h exp=0/0", bus.ex_a, bus.ex_b); end
        drive(16'hA312, 16'h0034);
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_opcode !== 4'd0) begin failures++; $display("FAIL t2_illegal got=%0h/%0h exp=0/0", bus.ex_valid, bus.ex_opcode); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(16'h6410, 16'h0040);
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 4'd6 || bus.ex_rd !== 4'd4) begin failures++; $display("FAIL t3_lw got=%0h/%0h/%0h exp=1/6/4", bus.ex_valid, bus.ex_opcode, bus.ex_rd); end
        drive(16'h1541, 16'h0041);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL t3_stall got=%0h exp=1", bus.STALL); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_opcode !== 4'd0) begin failures++; $display("FAIL t3_bubble got=%0h/%0h exp=0/0", bus.ex_valid, bus.ex_opcode); end
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t3_unstall got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== 4'd1 || bus.ex_rd !== 4'd5) begin failures++; $display("FAIL t3_add got=%0h/%0h/%0h exp=1/1/5", bus.ex_valid, bus.ex_opcode, bus.ex_rd); end
        checks++; if (bus.ex_a !== 16'd0 || bus.ex_b !== 16'd0) begin failures++; $display("FAIL t3_add_ops got=%h/%h exp=0/0", bus.ex_a, bus.ex_b); end
        drive(16'h6410, 16'h0042);
        tick();
        drive(16'h1123, 16'h0043);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t3_indep_stall got=%0h exp=0", bus.STALL); end
    endtask

    task automatic test_beq();
        apply_reset();
        wb_write(4'd1, 16'd9);
        wb_write(4'd2, 16'd9);
        drive(16'h8123, 16'h0010);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t4_stall got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.BRANCH !== 1'b1 || bus.branch_instr_addr !== 16'h0014) begin failures++; $display("FAIL t4_taken got=%0h/%h exp=1/0014", bus.BRANCH, bus.branch_instr_addr); end
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t4_beq_bubble got=%0h exp=0", bus.ex_valid); end
        drive(16'h9123, 16'h0011);
        tick();
        checks++; if (bus.BRANCH !== 1'b0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t4_flush1 got=%0h/%0h exp=0/0", bus.BRANCH, bus.ex_valid); end
        drive(16'hF000, 16'h0012);
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.dbg_state !== ST_RUN) begin failures++; $display("FAIL t4_flush2 got=%0h/%0h exp=0/%0h", bus.ex_valid, bus.dbg_state, ST_RUN); end
        drive(16'h1312, 16'h0014);
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_instr_addr !== 16'h0014 || bus.ex_a !== 16'd9) begin failures++; $display("FAIL t4_target_issue got=%0h/%h/%h exp=1/0014/0009", bus.ex_valid, bus.ex_instr_addr, bus.ex_a); end
        drive(16'h8130, 16'h0015);
        tick();
        checks++; if (bus.BRANCH !== 1'b0 || bus.ex_valid !== 1'b0 || bus.dbg_state !== ST_RUN) begin failures++; $display("FAIL t4_not_taken got=%0h/%0h/%0h exp=0/0/0", bus.BRANCH, bus.ex_valid, bus.dbg_state); end
        drive(16'h800E, 16'h0000);
        tick();
        checks++; if (bus.BRANCH !== 1'b1 || bus.branch_instr_addr !== 16'hFFFF) begin failures++; $display("FAIL t4_wrap got=%0h/%h exp=1/ffff", bus.BRANCH, bus.branch_instr_addr); end
        drive(16'h0000, 16'h0000);
        tick();
        tick();
    endtask

    task automatic test_beq_stall_jmp();
        apply_reset();
        drive(16'h1123, 16'h0050);
        tick();
        drive(16'h8120, 16'h0051);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL t5_stall_ex got=%0h exp=1", bus.STALL); end
        tick();
        checks++; if (bus.BRANCH !== 1'b0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t5_bubble1 got=%0h/%0h exp=0/0", bus.BRANCH, bus.ex_valid); end
        bus.mem_wr_en = 1'b1; bus.mem_rd = 4'd1;
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL t5_stall_mem got=%0h exp=1", bus.STALL); end
        tick();
        checks++; if (bus.BRANCH !== 1'b0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t5_bubble2 got=%0h/%0h exp=0/0", bus.BRANCH, bus.ex_valid); end
        bus.mem_wr_en = 1'b0; bus.mem_rd = 4'd0;
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t5_clear got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.BRANCH !== 1'b1 || bus.branch_instr_addr !== 16'h0052) begin failures++; $display("FAIL t5_resolve got=%0h/%h exp=1/0052", bus.BRANCH, bus.branch_instr_addr); end
        drive(16'h0000, 16'h0000);
        tick();
        tick();
        drive(16'h9ABC, 16'h5000);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t5_jmp_stall got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.BRANCH !== 1'b1 || bus.branch_instr_addr !== 16'h5ABC) begin failures++; $display("FAIL t5_jmp got=%0h/%h exp=1/5abc", bus.BRANCH, bus.branch_instr_addr); end
    endtask

    task automatic test_halt();
        apply_reset();
        drive(16'hF000, 16'h0060);
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t6_pre_stall got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.dbg_state !== ST_HALTED) begin failures++; $display("FAIL t6_state got=%0h exp=%0h", bus.dbg_state, ST_HALTED); end
        drive(16'h1312, 16'h0061);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (bus.STALL !== 1'b1 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t6_halted cyc=%0d got=%0h/%0h exp=1/0", i, bus.STALL, bus.ex_valid); end
        end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.STALL !== 1'b0 || bus.dbg_state !== ST_RUN) begin failures++; $display("FAIL t6_reset got=%0h/%0h exp=0/0", bus.STALL, bus.dbg_state); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wb_hazard();
        apply_reset();
        drive(16'h1312, 16'h0070);
        bus.wb_we = 1'b1; bus.wb_rd = 4'd2; bus.wb_data = 16'd3;
`ifdef ID_WB_BYPASS_EN
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t7_byp_stall got=%0h exp=0", bus.STALL); end
        tick();
        bus.wb_we = 1'b0;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 16'd3) begin failures++; $display("FAIL t7_byp got=%0h/%h exp=1/0003", bus.ex_valid, bus.ex_b); end
`else
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL t7_wb_stall got=%0h exp=1", bus.STALL); end
        tick();
        bus.wb_we = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL t7_wb_bubble got=%0h exp=0", bus.ex_valid); end
        @(negedge clk);
        checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL t7_wb_clear got=%0h exp=0", bus.STALL); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 16'd3) begin failures++; $display("FAIL t7_wb_issue got=%0h/%h exp=1/0003", bus.ex_valid, bus.ex_b); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_use();
        test_beq();
        test_beq_stall_jmp();
        test_halt();
        test_wb_hazard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
